// File: rtl/mips_mmio_uart_tx.sv
// MMIO UART transmitter: STATUS/TXDATA word registers feeding a byte FIFO and an 8N1 serialiser.
// Reads return one cycle after mmio_re; TXDATA writes to a full FIFO are dropped and flag overflow.
module mips_mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR    = 32'hffff0000,
  parameter int          CLKS_PER_BIT = 4,
  parameter int          FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mmio_addr,
  input  logic [31:0] mmio_wdata,
  input  logic        mmio_we,
  input  logic        mmio_re,
  output logic [31:0] mmio_rdata,
  output logic        tx_o,
  output logic        tx_busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_RELOAD = BW'(CLKS_PER_BIT - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          full;
  logic          empty;
  logic          overflow;

  logic [1:0]    state;
  logic [BW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;

  logic          hit;
  logic          sel_status;
  logic          sel_txdata;
  logic          push_req;
  logic          push;
  logic          pop;
  logic [31:0]   status;
  logic          unused_bits;

  assign unused_bits = ^{mmio_addr[1:0], mmio_wdata[31:8]};

  assign hit        = (mmio_addr[31:3] == BASE_ADDR[31:3]);
  assign sel_status = hit & ~mmio_addr[2];
  assign sel_txdata = hit &  mmio_addr[2];

  assign full     = (count == (AW+1)'(FIFO_DEPTH));
  assign empty    = (count == '0);
  assign pop      = (state == S_IDLE) & ~empty;
  assign push_req = mmio_we & sel_txdata;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign push     = push_req & (~full | pop);

  assign tx_busy = (state != S_IDLE) | ~empty;

  always_comb begin
    status           = '0;
    status[0]        = full;
    status[1]        = empty;
    status[2]        = tx_busy;
    status[3]        = overflow;
    status[4+AW:4]   = count;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= mmio_wdata[7:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
      if (push_req & full & ~pop)
        overflow <= 1'b1;
      else if (mmio_we & sel_status & mmio_wdata[3])
        overflow <= 1'b0;
    end
  end

  // Sampled before this cycle's write lands, so a combined we/re returns pre-write state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      mmio_rdata <= '0;
    else if (mmio_re)
      mmio_rdata <= sel_status ? status : '0;
  end

  // tx_o is loaded with the value of the bit being entered, so it changes with the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      tx_o     <= 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          if (pop) begin
            shift    <= mem[rd_ptr];
            baud_cnt <= BAUD_RELOAD;
            state    <= S_START;
            tx_o     <= 1'b0;
          end
        end
        S_START: begin
          if (baud_cnt == '0) begin
            baud_cnt <= BAUD_RELOAD;
            bit_idx  <= '0;
            state    <= S_DATA;
            tx_o     <= shift[0];
          end else begin
            baud_cnt <= baud_cnt - BW'(1);
          end
        end
        S_DATA: begin
          if (baud_cnt == '0) begin
            baud_cnt <= BAUD_RELOAD;
            if (bit_idx == 3'd7) begin
              state <= S_STOP;
              tx_o  <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              shift   <= {1'b0, shift[7:1]};
              tx_o    <= shift[1];
            end
          end else begin
            baud_cnt <= baud_cnt - BW'(1);
          end
        end
        default: begin
          if (baud_cnt == '0) begin
            state <= S_IDLE;
            tx_o  <= 1'b1;
          end else begin
            baud_cnt <= baud_cnt - BW'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mips_mmio_uart_tx.sv
// Bench for mips_mmio_uart_tx: directed scenarios plus random bus traffic
// compared cycle by cycle against a queue-based frame model.
module tb_mips_mmio_uart_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam logic [31:0] BASE = 32'hffff0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] mmio_addr;
  logic [31:0] mmio_wdata;
  logic        mmio_we;
  logic        mmio_re;
  logic [31:0] mmio_rdata;
  logic        tx_o;
  logic        tx_busy;

  int tests = 0;
  int fails = 0;

  mips_mmio_uart_tx #(.BASE_ADDR(BASE), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .mmio_addr(mmio_addr), .mmio_wdata(mmio_wdata),
    .mmio_we(mmio_we), .mmio_re(mmio_re),
    .mmio_rdata(mmio_rdata), .tx_o(tx_o), .tx_busy(tx_busy)
  );

  always #5 clk = ~clk;

  // Reference model: FIFO as a queue, frame as (byte, elapsed cycles).
  logic [7:0]  m_q[$];
  bit          m_act;
  int          m_t;
  logic [7:0]  m_byte;
  bit          m_ovf;
  logic [31:0] m_rdata;

  function automatic bit m_hit(input logic [31:0] a);
    return (a >> 3) == (BASE >> 3);
  endfunction

  function automatic logic [31:0] m_status();
    int n;
    n = m_q.size();
    return (n << 4) | (int'(m_ovf) << 3) | (int'(m_act || n != 0) << 2)
         | (int'(n == 0) << 1) | int'(n == DEPTH);
  endfunction

  function automatic logic m_tx();
    int k;
    if (!m_act) return 1'b1;
    k = m_t / CPB;
    if (k == 0) return 1'b0;
    if (k <= 8) return m_byte[k-1];
    return 1'b1;
  endfunction

  task automatic m_reset();
    m_q.delete();
    m_act = 0; m_t = 0; m_byte = '0; m_ovf = 0; m_rdata = '0;
  endtask

  task automatic m_clock(input logic we, input logic re, input logic [31:0] a, input logic [31:0] d);
    bit hit_st, hit_tx, pop;
    hit_st = m_hit(a) && !a[2];
    hit_tx = m_hit(a) && a[2];
    if (re) m_rdata = hit_st ? m_status() : 32'h0;
    pop = !m_act && m_q.size() != 0;
    if (m_act) begin
      m_t++;
      if (m_t == 10*CPB) m_act = 0;
    end
    if (pop) begin
      m_byte = m_q.pop_front();
      m_act = 1; m_t = 0;
    end
    if (we && hit_tx) begin
      if (m_q.size() < DEPTH) m_q.push_back(d[7:0]);
      else m_ovf = 1;
    end
    if (we && hit_st && d[3]) m_ovf = 0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input logic we, input logic re, input logic [31:0] a, input logic [31:0] d);
    mmio_we = we; mmio_re = re; mmio_addr = a; mmio_wdata = d;
    @(posedge clk);
    m_clock(we, re, a, d);
    #1;
    chk("tx_o", {31'b0, tx_o}, {31'b0, m_tx()});
    chk("tx_busy", {31'b0, tx_busy}, {31'b0, (m_act || m_q.size() != 0)});
    chk("rdata", mmio_rdata, m_rdata);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  initial begin
    logic [9:0] frame;
    int         waited;
    logic [31:0] a;
    int         op;

    rst = 1'b1; mmio_we = 0; mmio_re = 0; mmio_addr = '0; mmio_wdata = '0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_tx_o", {31'b0, tx_o}, 32'h1);
    chk("reset_busy", {31'b0, tx_busy}, 32'h0);
    chk("reset_rdata", mmio_rdata, 32'h0);
    @(negedge clk) rst = 1'b0;

    tick(1'b0, 1'b1, BASE, 32'h0);
    chk("status_after_reset", mmio_rdata, 32'h2);

    // Single frame with fixed expected waveform.
    frame = {1'b1, 8'hA5, 1'b0};
    tick(1'b1, 1'b0, BASE + 32'h4, 32'h000000A5);
    chk("a5_first_cycle_idle", {31'b0, tx_o}, 32'h1);
    for (int m = 1; m <= 40; m++) begin
      idle(1);
      chk("a5_wave", {31'b0, tx_o}, {31'b0, frame[(m-1)/CPB]});
      chk("a5_busy", {31'b0, tx_busy}, 32'h1);
    end
    idle(1);
    chk("a5_busy_fall", {31'b0, tx_busy}, 32'h0);
    chk("a5_line_idle", {31'b0, tx_o}, 32'h1);

    // Six back-to-back writes: one popped early, four buffered, one dropped.
    for (int i = 1; i <= 6; i++) tick(1'b1, 1'b0, BASE + 32'h4, 32'h11 * i);
    tick(1'b0, 1'b1, BASE, 32'h0);
    chk("overflow_status", mmio_rdata, 32'h4D);
    tick(1'b1, 1'b0, BASE, 32'h8);
    tick(1'b0, 1'b1, BASE, 32'h0);
    chk("overflow_cleared", mmio_rdata, 32'h45);
    waited = 0;
    while ((m_act || m_q.size() != 0) && waited < 400) begin idle(1); waited++; end
    chk("drain_timeout", {31'b0, (m_act || m_q.size() != 0)}, 32'h0);
    idle(2);

    // Reset in the middle of data bit 3.
    tick(1'b1, 1'b0, BASE + 32'h4, 32'h3C);
    waited = 0;
    while (!(m_act && m_t == 4*CPB + 1) && waited < 100) begin idle(1); waited++; end
    chk("reach_bit3", {31'b0, (m_act && m_t == 4*CPB + 1)}, 32'h1);
    chk("bit3_line", {31'b0, tx_o}, 32'h1);
    rst = 1'b1;
    #1;
    chk("midframe_rst_tx_o", {31'b0, tx_o}, 32'h1);
    chk("midframe_rst_busy", {31'b0, tx_busy}, 32'h0);
    m_reset();
    @(posedge clk); #1;
    chk("rst_hold_tx_o", {31'b0, tx_o}, 32'h1);
    @(negedge clk) rst = 1'b0;
    tick(1'b0, 1'b1, BASE, 32'h0);
    chk("status_after_midrst", mmio_rdata, 32'h2);
    idle(50);

    // Decode misses and write-only TXDATA reads.
    tick(1'b1, 1'b0, 32'hffff0008, 32'h55);
    tick(1'b1, 1'b0, 32'hfffe0004, 32'h66);
    chk("miss_no_push", {31'b0, tx_busy}, 32'h0);
    tick(1'b0, 1'b1, BASE, 32'h0);
    tick(1'b0, 1'b1, 32'hffff0008, 32'h0);
    chk("miss_read_8", mmio_rdata, 32'h0);
    tick(1'b0, 1'b1, BASE, 32'h0);
    tick(1'b0, 1'b1, 32'hfffe0004, 32'h0);
    chk("miss_read_fffe", mmio_rdata, 32'h0);
    tick(1'b0, 1'b1, BASE, 32'h0);
    tick(1'b0, 1'b1, BASE + 32'h4, 32'h0);
    chk("txdata_read", mmio_rdata, 32'h0);
    idle(2);

    // Random traffic against the model.
    for (int i = 0; i < 700; i++) begin
      op = $urandom_range(0, 9);
      a  = BASE | 32'($urandom_range(0, 3));
      case (op)
        0, 1, 2, 3: tick(1'b1, 1'b0, a | 32'h4, $urandom);
        4:          tick(1'b0, 1'b1, a, $urandom);
        5:          tick(1'b1, $urandom_range(0, 1) == 1, a, $urandom);
        6:          tick(1'b0, 1'b1, a | 32'h4, $urandom);
        7: begin
          case ($urandom_range(0, 3))
            0:       a = 32'hffff0008;
            1:       a = 32'hfffe0004;
            2:       a = 32'hffff000c;
            default: a = 32'h00000004;
          endcase
          tick($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, a, $urandom);
        end
        8:          tick(1'b1, 1'b1, a | 32'h4, $urandom);
        default:    idle(1 + $urandom_range(0, 30));
      endcase
    end
    waited = 0;
    while ((m_act || m_q.size() != 0) && waited < 400) begin idle(1); waited++; end
    chk("final_drain", {31'b0, (m_act || m_q.size() != 0)}, 32'h0);
    tick(1'b0, 1'b1, BASE, 32'h0);
    chk("final_status_empty", mmio_rdata & 32'h7, 32'h2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
